// File: rtl/sub_32_seq.sv
// Multi-cycle 32-bit unsigned subtractor, one SLICE_W-bit slice per clock; done N_SLICE+1 cycles after accept.
// No backpressure: start is taken only in IDLE and ignored otherwise. Signed overflow flag under SUB_SEQ_OVF_EN.
module sub_32_seq #(
  parameter int SLICE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [32:0] D,
  output logic        ovf
);

  localparam int N_SLICE = 32 / SLICE_W;
  localparam int CNT_W   = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic               last_slice;

  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [CNT_W-1:0]   cnt;
  logic               borrow;
  logic [32:0]        d_q;

  logic [5:0]         base;
  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W:0]   sub_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == LAST_CNT) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign last_slice = (state == CALC) && (cnt == LAST_CNT);

  // Slice base offset; at most 31, so 6 bits cover every legal SLICE_W.
  assign base    = 6'(cnt) * 6'(SLICE_W);
  assign a_sl    = a_q[base +: SLICE_W];
  assign b_sl    = b_q[base +: SLICE_W];
  assign sub_res = {1'b0, a_sl} - {1'b0, b_sl} - {{SLICE_W{1'b0}}, borrow};

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      d_q    <= '0;
    end else if (accept) begin
      a_q    <= A;
      b_q    <= B;
      cnt    <= '0;
      borrow <= 1'b0;
      d_q    <= '0;
    end else if (state == CALC) begin
      d_q[base +: SLICE_W] <= sub_res[SLICE_W-1:0];
      borrow               <= sub_res[SLICE_W];
      if (last_slice) begin
        d_q[32] <= sub_res[SLICE_W];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign D = d_q;

`ifdef SUB_SEQ_OVF_EN
  logic ovf_q;

  // The final slice always holds bit 31, so its diff MSB is the result sign.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= 1'b0;
    end else if (last_slice) begin
      ovf_q <= (a_q[31] ^ b_q[31]) & (a_q[31] ^ sub_res[SLICE_W-1]);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
